// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Sequential-PC instruction fetch feeding a 2-entry {inst, pc}
//               queue; redirect flush, halt-word stop. Optional macro
//               FETCH_ALIGN_CHECK_EN adds the sticky misaligned-redirect fault.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        halted
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  localparam logic [1:0]  c_depth = 2'd2;
  localparam logic [31:0] c_step  = 32'd4;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_q_inst [0:1];
  logic [31:0] r_q_pc   [0:1];
  logic [1:0]  r_count;

  logic        w_deq;
  logic        w_enq;
  logic        w_is_halt;
  logic        w_misaligned;
  logic [31:0] w_redirect_target;

  assign w_deq             = (r_count != 2'd0) && inst_ready;
  assign w_enq             = (r_state == S_RUN) && ((r_count < c_depth) || w_deq);
  assign w_is_halt         = (imem_data == HALT_WORD);
  assign w_redirect_target = redirect_pc & ~32'h0000_0003;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;
  assign w_misaligned = (redirect_pc[1:0] != 2'b00);
  assign fault        = r_fault;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (redirect_valid && w_misaligned) begin
      r_fault <= 1'b1;
    end
  end
`else
  assign w_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= 2'd0;
      r_state    <= S_RUN;
    end else if (redirect_valid) begin
      // Flush wins over any same-cycle fetch or dequeue.
      r_count <= 2'd0;
      if (w_misaligned) begin
        r_state <= S_HALTED;
      end else begin
        r_state    <= S_RUN;
        r_fetch_pc <= w_redirect_target;
      end
    end else begin
      case ({w_enq, w_deq})
        2'b01: begin
          r_q_inst[0] <= r_q_inst[1];
          r_q_pc[0]   <= r_q_pc[1];
          r_count     <= r_count - 2'd1;
        end
        2'b10: begin
          r_q_inst[r_count[0]] <= imem_data;
          r_q_pc[r_count[0]]   <= r_fetch_pc;
          r_count              <= r_count + 2'd1;
        end
        2'b11: begin
          if (r_count == c_depth) begin
            r_q_inst[0] <= r_q_inst[1];
            r_q_pc[0]   <= r_q_pc[1];
            r_q_inst[1] <= imem_data;
            r_q_pc[1]   <= r_fetch_pc;
          end else begin
            r_q_inst[0] <= imem_data;
            r_q_pc[0]   <= r_fetch_pc;
          end
        end
        default: ;
      endcase
      // The halt word freezes fetch_pc on its own address.
      if (w_enq) begin
        if (w_is_halt) begin
          r_state <= S_HALTED;
        end else begin
          r_fetch_pc <= r_fetch_pc + c_step;
        end
      end
    end
  end

  assign imem_addr  = r_fetch_pc;
  assign inst_valid = (r_count != 2'd0);
  assign inst       = r_q_inst[0];
  assign inst_pc    = r_q_pc[0];
  assign halted     = (r_state == S_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench; queue-based reference model of the fetch
//               unit plus directed scenarios and a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault;
`endif

  // memory image controls
  logic [31:0] salt = 32'h1234_5678;
  logic        fixed_mode = 1'b0;
  logic        halt_en = 1'b0;
  logic [31:0] halt_addr = 32'h0;

  int n_pass = 0;
  int n_total = 0;

  // reference model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic [31:0] m_pc = RESET_PC;
  logic        m_halted = 1'b0;
  logic        m_fault = 1'b0;

  instruction_fetch #(.RESET_PC(RESET_PC), .HALT_WORD(HALT_WORD)) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inst_valid(inst_valid),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_ready(inst_ready),
    .halted(halted)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fault(fault)
`endif
  );

  always #5 clk = ~clk;

  // Default words end in 2'b01 so they can never alias the halt word.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s,
                                           input logic fx, input logic hen, input logic [31:0] ha);
    if (hen && a == ha) return HALT_WORD;
    if (fx && a == 32'h0) return 32'h0000_0011;
    if (fx && a == 32'h4) return 32'h0000_0022;
    if (fx && a == 32'h8) return 32'h0000_0033;
    return {a[31:2] ^ s[29:0], 2'b01};
  endfunction

  assign imem_data = mem_word(imem_addr, salt, fixed_mode, halt_en, halt_addr);

  function automatic logic [98:0] exp_vec();
    logic        v;
    logic [31:0] p;
    logic [31:0] w;
    v = (mq_pc.size() != 0);
    p = v ? mq_pc[0] : 32'h0;
    w = v ? mq_inst[0] : 32'h0;
    return {m_fault, v, m_halted, m_pc, p, w};
  endfunction

  function automatic logic [98:0] obs_vec();
    logic f;
`ifdef FETCH_ALIGN_CHECK_EN
    f = fault;
`else
    f = 1'b0;
`endif
    return {f, inst_valid, halted, imem_addr,
            inst_valid ? inst_pc : 32'h0, inst_valid ? inst : 32'h0};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return at negedge.
  task automatic tick(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    logic [31:0] w;
    logic        deq;
    logic        enq;
    rst = r; redirect_valid = rv; redirect_pc = rp; inst_ready = rdy;
    @(posedge clk);
    w = mem_word(m_pc, salt, fixed_mode, halt_en, halt_addr);
    if (r) begin
      mq_pc.delete(); mq_inst.delete();
      m_pc = RESET_PC; m_halted = 1'b0; m_fault = 1'b0;
    end else if (rv) begin
      mq_pc.delete(); mq_inst.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      if (rp[1:0] != 2'b00) begin
        m_halted = 1'b1; m_fault = 1'b1;
      end else begin
        m_pc = rp; m_halted = 1'b0;
      end
`else
      m_pc = {rp[31:2], 2'b00}; m_halted = 1'b0;
`endif
    end else begin
      deq = (mq_pc.size() != 0) && rdy;
      enq = !m_halted && (mq_pc.size() < 2 || deq);
      if (deq) begin
        void'(mq_pc.pop_front()); void'(mq_inst.pop_front());
      end
      if (enq) begin
        mq_pc.push_back(m_pc); mq_inst.push_back(w);
        if (w == HALT_WORD) m_halted = 1'b1;
        else m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    n_total++;
    if ({inst_valid, halted, imem_addr} !== {1'b0, 1'b0, RESET_PC})
      $display("FAIL reset got v=%b h=%b addr=%h exp v=0 h=0 addr=%h", inst_valid, halted, imem_addr, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] words [0:2];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    fixed_mode = 1'b1;
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      n_total++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, 32'(4 * i), words[i]})
        $display("FAIL stream%0d got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                 i, inst_valid, inst_pc, inst, 32'(4 * i), words[i]);
      else n_pass++;
    end
    fixed_mode = 1'b0;
  endtask

  task automatic test_backpressure();
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      n_total++;
      if (obs_vec() !== exp_vec())
        $display("FAIL stall%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
      if (i >= 1) begin
        n_total++;
        if (imem_addr !== 32'h8) $display("FAIL stall_addr%0d got=%h exp=00000008", i, imem_addr);
        else n_pass++;
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({inst_valid, inst_pc} !== {1'b1, 32'(4 * i)})
        $display("FAIL drain%0d got v=%b pc=%h exp v=1 pc=%h", i, inst_valid, inst_pc, 32'(4 * i));
      else n_pass++;
      tick(1'b0, 1'b0, 32'h0, 1'b1);
    end
  endtask

  task automatic test_redirect_full();
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 32'h40, 1'b1);
    n_total++;
    if ({inst_valid, imem_addr} !== {1'b0, 32'h40})
      $display("FAIL redir_bubble got v=%b addr=%h exp v=0 addr=00000040", inst_valid, imem_addr);
    else n_pass++;
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_total++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h40})
      $display("FAIL redir_target got v=%b pc=%h exp v=1 pc=00000040", inst_valid, inst_pc);
    else n_pass++;
  endtask

  task automatic test_halt();
    halt_en = 1'b1; halt_addr = 32'hC;
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL halt%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_total++;
    if ({halted, inst_valid, imem_addr} !== {1'b1, 1'b0, 32'hC})
      $display("FAIL halt_state got h=%b v=%b addr=%h exp h=1 v=0 addr=0000000c", halted, inst_valid, imem_addr);
    else n_pass++;
    halt_en = 1'b0;
    tick(1'b0, 1'b1, 32'h0, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_total++;
    if ({halted, inst_valid, inst_pc} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL halt_resume got h=%b v=%b pc=%h exp h=0 v=1 pc=00000000", halted, inst_valid, inst_pc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_total++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_last got v=%b pc=%h exp v=1 pc=fffffffc", inst_valid, inst_pc);
    else n_pass++;
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_total++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h0})
      $display("FAIL wrap_zero got v=%b pc=%h exp v=1 pc=00000000", inst_valid, inst_pc);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    tick(1'b0, 1'b1, 32'h42, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
    n_total++;
    if ({fault, halted, inst_valid} !== 3'b110)
      $display("FAIL misalign got f=%b h=%b v=%b exp f=1 h=1 v=0", fault, halted, inst_valid);
    else n_pass++;
    tick(1'b0, 1'b1, 32'h40, 1'b1);
    n_total++;
    if ({fault, halted} !== 2'b10)
      $display("FAIL misalign_resume got f=%b h=%b exp f=1 h=0", fault, halted);
    else n_pass++;
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    n_total++;
    if ({fault, halted, imem_addr} !== {2'b00, RESET_PC})
      $display("FAIL misalign_rst got f=%b h=%b addr=%h exp f=0 h=0 addr=%h", fault, halted, imem_addr, RESET_PC);
    else n_pass++;
`else
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    n_total++;
    if ({inst_valid, inst_pc} !== {1'b1, 32'h40})
      $display("FAIL misalign_trunc got v=%b pc=%h exp v=1 pc=00000040", inst_valid, inst_pc);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    tick(1'b1, 1'b1, 32'h80, 1'b1);
    n_total++;
    if ({inst_valid, halted, imem_addr} !== {2'b00, RESET_PC})
      $display("FAIL rst_mid got v=%b h=%b addr=%h exp v=0 h=0 addr=%h", inst_valid, halted, imem_addr, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_random();
    logic        r, rv, rdy;
    logic [31:0] rp;
    halt_en = 1'b1; halt_addr = 32'h24; salt = $urandom;
    tick(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rp  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 63));
      tick(r, rv, rp, rdy);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL random%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    halt_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_halt();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, giving the instruction encoding that stops fetching.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: byte address presented to instruction memory.
REQ-006 The block SHALL have port imem_data, input, 32 bits: big-endian word returned combinationally for imem_addr in the same cycle.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits: redirect target byte address.
REQ-009 The block SHALL have port inst_valid, output, 1 bit: the queue head holds an instruction.
REQ-010 The block SHALL have port inst, output, 32 bits: the instruction word at the queue head.
REQ-011 The block SHALL have port inst_pc, output, 32 bits: the byte address of inst.
REQ-012 The block SHALL have port inst_ready, input, 1 bit: the decode stage accepts the head.
REQ-013 The block SHALL have port halted, output, 1 bit: asserted in state HALTED.
REQ-014 The block SHALL have port fault, output, 1 bit: sticky misaligned-redirect flag; present only with FETCH_ALIGN_CHECK_EN.

Function
REQ-015 The block SHALL hold fetch_pc, a 2-entry FIFO of {inst, pc}, a 2-bit count, and a state register with states RUN and HALTED.
REQ-016 imem_addr SHALL equal fetch_pc combinationally at all times.
REQ-017 Dequeue SHALL occur at an edge where inst_valid && inst_ready; inst_valid = (count != 0); inst and inst_pc SHALL show the head entry.
REQ-018 Enqueue SHALL occur in RUN with no redirect when count < 2, or when count == 2 and a dequeue happens in the same cycle; it writes {imem_data, fetch_pc} and sets fetch_pc <= fetch_pc + 4.
REQ-019 Enqueue and dequeue in the same cycle SHALL leave count unchanged and preserve order.
REQ-020 fetch_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-021 An enqueued word equal to HALT_WORD SHALL be queued normally; the state SHALL move RUN->HALTED at the same edge, after which no enqueue happens, while queued entries still drain.
REQ-022 redirect_valid SHALL have priority over all else: at that edge count <= 0 and fetch_pc <= redirect_pc; the same-cycle fetch and any same-cycle dequeue are discarded; the state goes to RUN, also from HALTED.
REQ-023 After a redirect, inst_valid SHALL be 0 for exactly one cycle; the target instruction is valid the cycle after.
REQ-024 Fetch-to-valid latency SHALL be one cycle; with inst_ready held high, throughput SHALL be one instruction per cycle.

Reset
REQ-025 When rst is high at an edge: fetch_pc <= RESET_PC, count <= 0, state <= RUN, fault <= 0; inst_valid = 0 and halted = 0 in the following cycle.
REQ-026 rst SHALL override redirect_valid, and reset mid-operation SHALL drop all queued entries.
REQ-027 The first fetch (address RESET_PC) SHALL occur in the first cycle with rst low; its instruction is valid one cycle later.

Configuration
REQ-028 With macro FETCH_ALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0] != 0 SHALL flush the queue, set fault = 1, and enter HALTED; fault clears only on rst, and a later aligned redirect returns the block to RUN with fault still set.
REQ-029 Without FETCH_ALIGN_CHECK_EN, the fault port SHALL be absent, and a redirect SHALL load {redirect_pc[31:2], 2'b00}.

Verification
REQ-030 Reset, then rst low with inst_ready = 1, memory words 0x11, 0x22, 0x33 -> inst_valid rises one cycle after reset release; inst_pc sequence 0, 4, 8 on consecutive cycles.
REQ-031 inst_ready = 0 for 5 cycles -> count saturates at 2, fetch_pc stays at 8, imem_addr is stable; after inst_ready = 1, the output is 0, 4, 8 in order with no loss or duplication.
REQ-032 Redirect to 0x40 while count = 2 and inst_ready = 1 -> no entry accepted that cycle, inst_valid = 0 for one cycle, then inst_pc = 0x40.
REQ-033 Word 0xFFFF_FFFF at address 0x0C -> halted rises after it is enqueued, the entries drain, fetch_pc stays at 0x0C; a redirect to 0 resumes fetching.
REQ-034 Redirect to 0xFFFF_FFFC -> inst_pc sequence 0xFFFF_FFFC, then 0x0000_0000.
REQ-035 With FETCH_ALIGN_CHECK_EN, redirect to 0x42 -> fault = 1, halted = 1, inst_valid = 0; then rst -> fault = 0 and fetch restarts at RESET_PC.
